// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the M-extension scheduler:
// state encoding, default latencies and funct3 decode.
package muldiv_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } md_state_e;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    // funct3 bit that separates DIV/REM from MUL
    localparam int DIV_BIT = 2;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/muldiv_sched_iter_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
// Tracks remaining BUSY cycles of the iterative unit.
module iter_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sched.sv
// E-stage scheduler for the iterative MUL/DIV unit:
// launches ops, stalls the front pipe and presents the result.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E_MulDiv,
    input  logic [2:0] E_funct3,
    input  logic       E_DivZero,
    input  logic       Kill,
    input  logic       Hold,
    output logic       md_start,
    output logic       md_abort,
    output logic [2:0] md_op,
    output logic       F_Stall,
    output logic       D_Stall,
    output logic       E_Stall,
    output logic       M_Bubble,
    output logic       md_valid
);

    localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

    md_state_e     state_q, state_d;
    logic [2:0]    md_op_q, md_op_d;
    logic          start, abort, stall, valid;
    logic          cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_val;
    logic          is_div;

    assign is_div = E_funct3[DIV_BIT];

    iter_counter #(
        .W(CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .load_i(cnt_load),
        .val_i (cnt_val),
        .dec_i (cnt_dec),
        .zero_o(cnt_zero)
    );

    // Outputs are gated by rst_n so they drop the instant reset asserts
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        abort    = 1'b0;
        stall    = 1'b0;
        valid    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = MUL_LD;
        if (rst_n) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!Kill && E_MulDiv) begin
                        start = 1'b1;
                        stall = 1'b1;
                        if (is_div && E_DivZero) begin
                            state_d = S_DONE;
                        end else begin
                            state_d  = S_BUSY;
                            cnt_load = 1'b1;
                            cnt_val  = is_div ? DIV_LD : MUL_LD;
                        end
                    end
                end
                S_BUSY: begin
                    if (Kill) begin
                        abort   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stall   = 1'b1;
                        cnt_dec = 1'b1;
                        if (cnt_zero) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (Kill) begin
                        abort   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        valid = 1'b1;
                        if (!Hold) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Bypass so md_op already shows the new funct3 in the start cycle
    assign md_op_d = start ? E_funct3 : md_op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            md_op_q <= 3'b000;
        end else begin
            state_q <= state_d;
            md_op_q <= md_op_d;
        end
    end

    assign md_start = start;
    assign md_abort = abort;
    assign md_op    = md_op_d;
    assign F_Stall  = stall;
    assign D_Stall  = stall;
    assign E_Stall  = stall;
    assign M_Bubble = stall;
    assign md_valid = valid;

endmodule
